// File: rtl/dunit_step_ctrl.sv
// Debug-unit execution controller: run/step/halt gating of the pipeline clock enable,
// plus a byte-serial dump of the pipeline/register snapshot over the UART TX side.
`timescale 1ns/1ps

// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | pipeline frozen, decoding 'C' / 'S' / 'D'
// RUN       | pipeline free-running until HALT retires or 'H' arrives
// STEP      | pipeline enabled for exactly one cycle
// ACK       | one ack byte (0x06 step done, 0xFE halted) offered to TX
// DUMP_LOAD | snapshot word selected and captured into the shift register
// DUMP_SEND | current word shifted out low byte first
module dunit_step_ctrl #(
    parameter int NB_DATA = 8,
    parameter int NB_REG  = 32,
    parameter int N_WORDS = 8,
    parameter int NB_WIDX = 3
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    input  logic               i_halt,
    output logic               o_dunit_clk_en,
    output logic [NB_WIDX-1:0] o_word_idx,
    input  logic [NB_REG-1:0]  i_word_data,
    output logic               o_busy
);

    localparam int N_BYTES = NB_REG / NB_DATA;
    localparam int NB_BIDX = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    localparam logic [NB_BIDX-1:0] LAST_BYTE = NB_BIDX'(N_BYTES - 1);
    localparam logic [NB_WIDX-1:0] LAST_WORD = NB_WIDX'(N_WORDS - 1);

    localparam logic [NB_DATA-1:0] CMD_RUN  = NB_DATA'(8'h43);
    localparam logic [NB_DATA-1:0] CMD_STEP = NB_DATA'(8'h53);
    localparam logic [NB_DATA-1:0] CMD_DUMP = NB_DATA'(8'h44);
    localparam logic [NB_DATA-1:0] CMD_HALT = NB_DATA'(8'h48);
    localparam logic [NB_DATA-1:0] ACK_STEP = NB_DATA'(8'h06);
    localparam logic [NB_DATA-1:0] ACK_HALT = NB_DATA'(8'hFE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_ACK,
        ST_DUMP_LOAD,
        ST_DUMP_SEND
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [NB_DATA-1:0]   tx_data_q;
    logic                 tx_valid_q;
    logic [NB_DATA-1:0]   ack_code_q;
    logic [NB_REG-1:0]    shift_q;
    logic [NB_REG-1:0]    shift_next;
    logic [NB_WIDX-1:0]   word_q;
    logic [NB_BIDX-1:0]   byte_q;
    logic                 tx_fire;
    logic                 rx_cmd_run;
    logic                 rx_cmd_step;
    logic                 rx_cmd_dump;
    logic                 rx_cmd_halt;

    assign tx_fire     = tx_valid_q & i_tx_ready;
    assign rx_cmd_run  = i_rx_valid && (i_rx_data == CMD_RUN);
    assign rx_cmd_step = i_rx_valid && (i_rx_data == CMD_STEP);
    assign rx_cmd_dump = i_rx_valid && (i_rx_data == CMD_DUMP);
    assign rx_cmd_halt = i_rx_valid && (i_rx_data == CMD_HALT);
    assign shift_next  = shift_q >> NB_DATA;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_cmd_run) begin
                    state_d = i_halt ? ST_ACK : ST_RUN;
                end else if (rx_cmd_step) begin
                    state_d = i_halt ? ST_ACK : ST_STEP;
                end else if (rx_cmd_dump) begin
                    state_d = ST_DUMP_LOAD;
                end
            end
            // A retiring HALT takes priority over a simultaneous 'H'
            ST_RUN: begin
                if (i_halt) begin
                    state_d = ST_ACK;
                end else if (rx_cmd_halt) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: state_d = ST_ACK;
            ST_ACK: begin
                if (tx_fire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DUMP_LOAD: state_d = ST_DUMP_SEND;
            ST_DUMP_SEND: begin
                if (tx_fire && (byte_q == LAST_BYTE)) begin
                    state_d = (word_q == LAST_WORD) ? ST_IDLE : ST_DUMP_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_dunit_clk_en = 1'b0;
        unique case (state_q)
            ST_RUN:  o_dunit_clk_en = ~i_halt;
            ST_STEP: o_dunit_clk_en = 1'b1;
            default: o_dunit_clk_en = 1'b0;
        endcase
        o_busy = (state_q != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            ack_code_q <= '0;
            shift_q    <= '0;
            word_q     <= '0;
            byte_q     <= '0;
        end else begin
            if ((state_d == ST_ACK) && (state_q != ST_ACK)) begin
                ack_code_q <= (state_q == ST_STEP) ? ACK_STEP : ACK_HALT;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (state_d == ST_DUMP_LOAD) begin
                        word_q <= '0;
                        byte_q <= '0;
                    end
                end
                // Ack byte is presented the cycle after ACK is entered, then held until taken
                ST_ACK: begin
                    if (!tx_valid_q) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= ack_code_q;
                    end else if (i_tx_ready) begin
                        tx_valid_q <= 1'b0;
                        tx_data_q  <= '0;
                    end
                end
                ST_DUMP_LOAD: begin
                    shift_q    <= i_word_data;
                    tx_data_q  <= i_word_data[NB_DATA-1:0];
                    tx_valid_q <= 1'b1;
                    byte_q     <= '0;
                end
                ST_DUMP_SEND: begin
                    if (tx_fire) begin
                        if (byte_q == LAST_BYTE) begin
                            tx_valid_q <= 1'b0;
                            tx_data_q  <= '0;
                            if (word_q != LAST_WORD) begin
                                word_q <= word_q + NB_WIDX'(1);
                            end
                        end else begin
                            shift_q   <= shift_next;
                            tx_data_q <= shift_next[NB_DATA-1:0];
                            byte_q    <= byte_q + NB_BIDX'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = tx_valid_q;
    assign o_word_idx = word_q;

endmodule
